qsfp_scan_decode: RTL and testbench
===================================

// Module: qsfp_scan_decode
// PURPOSE
//  Downstream consumer of the QSFP I2C poller's byte buffer (readAddress/readData port).
//  On each buffer-update strobe: freeze the buffer, walk the SFF-8636 monitor bytes of every module,
//  and assemble them into 16-bit temperature, Vcc and 4-lane RX power words.
//  Publishes all words atomically to the GPIO/CSR layer, with optional threshold alarms.
// PARAMETERS
//  QSFP_COUNT    2   number of QSFP modules in the buffer (buffer address = {module, byte[7:0]})
//  READ_LATENCY  1   clk cycles from readAddress change to valid readData (1..4)
//  FREEZE_SETTLE 2   clk cycles between bufferFreeze rise and first address issue
// PORTS
//  clk            in   1                clock
//  rst            in   1                async active-high reset
//  bufferUpdated  in   1                1-cycle strobe from poller: new I2C data in buffer
//  readAddress    out  $clog2(QC)+8     buffer byte address {module, byte}
//  readData       in   8                buffer byte, valid READ_LATENCY cycles after address
//  bufferFreeze   out  1                holds poller buffer stable while high
//  scanBusy       out  1                high from scan start to publish
//  scanDone       out  1                1-cycle pulse on publish
//  scanCount      out  16               completed scans, wraps 0xFFFF->0x0000
//  tempOut        out  QC*16            signed temp, 1/256 degC, module i at [16i+:16]
//  vccOut         out  QC*16            unsigned Vcc, 100 uV LSB
//  rxPowerOut     out  QC*64            unsigned RX power, 0.1 uW LSB, lane L of module i at [64i+16L+:16]
//  tempHighLimit  in   16               signed alarm threshold (QSFP_SCAN_ALARM_EN)
//  rxLowLimit     in   16               unsigned alarm threshold (QSFP_SCAN_ALARM_EN)
//  alarm          out  QC               per-module alarm, updated at publish
// BEHAVIOUR
//  - Reset: outputs 0 (readAddress, bufferFreeze, scanBusy, scanDone, scanCount, all data words, alarm);
//    FSM to IDLE; pending flag cleared.
//  - Byte list per module, index 0..11: 22,23 temp; 26,27 Vcc; 34..41 RX1..RX4. MSB first in each pair.
//  - FSM states:
//    IDLE   : on bufferUpdated or pending -> FREEZE; set bufferFreeze and scanBusy; clear pending.
//    FREEZE : count FREEZE_SETTLE cycles -> ADDR (module=0, idx=0).
//    ADDR   : drive readAddress={module, BYTE[idx]} -> WAIT.
//    WAIT   : READ_LATENCY-1 cycles, then sample readData into shadow word -> ADDR for next idx.
//             After idx 11: advance module; after last module -> PUBLISH.
//    PUBLISH: copy shadow to outputs in one cycle; pulse scanDone; scanCount+1;
//             drop bufferFreeze and scanBusy -> IDLE.
//  - Timing: each byte takes READ_LATENCY+1 cycles. Scan length =
//    1 + FREEZE_SETTLE + QC*12*(READ_LATENCY+1) + 1 cycles.
//  - Output words change only in PUBLISH; no partial update is ever visible.
//  - bufferUpdated outside IDLE sets pending; multiple strobes coalesce into one rescan
//    that starts the cycle after return to IDLE.
//  - Reset mid-scan: immediate return to reset state; bufferFreeze released; published words cleared.
//  - readAddress holds its last value in IDLE.
// CONFIGURATION
//  QSFP_SCAN_ALARM_EN defined:
//    alarm[i] = ($signed(temp_i) > $signed(tempHighLimit)) | (any rx lane_i < rxLowLimit),
//    evaluated on shadow values and registered at PUBLISH.
//  QSFP_SCAN_ALARM_EN undefined: alarm tied 0; limit inputs unused; no comparator logic.
// STRUCTURE
//  - Package qsfp_scan_pkg:
//    NBYTES=12; BYTE_OFFSET[0:11] table; word indices TEMP=0, VCC=1, RX0..RX3=2..5;
//    FSM state encoding.
//  - Sub-module qsfp_scan_alarm: per-module comparator, compiled only under QSFP_SCAN_ALARM_EN.
// TESTING
//  1. Buffer model (READ_LATENCY=1, QC=2) with mod0 bytes 22/23=0x19,0x80 and mod1 22/23=0xFF,0x00;
//     one strobe -> tempOut=={16'hFF00,16'h1980}; scanDone after 1+2+48+1=52 cycles; scanCount=1.
//  2. Scan in progress -> bufferFreeze high throughout and readAddress visits exactly 24 addresses
//     in order 0x016,0x017,0x01A..0x029, then 0x116...; no output change before scanDone.
//  3. Three strobes during a scan -> exactly one rescan follows; scanCount increments by 2 in total.
//  4. Assert rst at byte 7 of module 1 -> bufferFreeze=0 and outputs 0 next cycle;
//     a new strobe after release -> complete correct scan.
//  5. ALARM_EN, tempHighLimit=0x3000, rxLowLimit=0x0010, mod0 RX3=0x000F, mod1 nominal
//     -> alarm=2'b01; undefined macro -> alarm=0.
//  6. Preload scanCount near wrap (65535 scans or forced) -> next scan gives scanCount=0x0000;
//     READ_LATENCY=3 rerun of test 1 -> identical data, scanDone at cycle 100.

Source files
------------

// File: rtl/qsfp_scan_pkg.sv
// qsfp_scan_pkg: shared constants for the QSFP monitor scanner.
// Holds the per-module SFF-8636 byte walk table, the shadow word layout and the FSM encoding.
package qsfp_scan_pkg;

    localparam int unsigned NBYTES = 12;
    localparam int unsigned NWORDS = 6;

    // Monitor bytes in walk order; each pair is MSB then LSB of one word.
    localparam logic [7:0] BYTE_OFFSET [0:NBYTES-1] = '{
        8'd22, 8'd23, 8'd26, 8'd27,
        8'd34, 8'd35, 8'd36, 8'd37, 8'd38, 8'd39, 8'd40, 8'd41
    };

    localparam int unsigned W_TEMP = 0;
    localparam int unsigned W_VCC  = 1;
    localparam int unsigned W_RX0  = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FREEZE  = 3'd1,
        S_ADDR    = 3'd2,
        S_WAIT    = 3'd3,
        S_PUBLISH = 3'd4
    } scan_state_t;

endpackage

// File: rtl/qsfp_scan_alarm.sv
// qsfp_scan_alarm: per-module threshold comparator (over-temperature or any low RX lane).
// Built only when QSFP_SCAN_ALARM_EN is defined.
`ifdef QSFP_SCAN_ALARM_EN
module qsfp_scan_alarm (
    input  logic [15:0] temp,
    input  logic [63:0] rx_power,
    input  logic [15:0] temp_high_limit,
    input  logic [15:0] rx_low_limit,
    output logic        alarm
);

    always_comb begin
        alarm = ($signed(temp) > $signed(temp_high_limit));
        for (int unsigned l = 0; l < 4; l++) begin
            if (rx_power[16*l +: 16] < rx_low_limit) alarm = 1'b1;
        end
    end

endmodule
`endif

// File: rtl/qsfp_scan_decode.sv
// qsfp_scan_decode: freezes the QSFP poller buffer, walks each module's monitor bytes and
// publishes temp/Vcc/RX power words atomically. Threshold alarms built with QSFP_SCAN_ALARM_EN.
module qsfp_scan_decode
    import qsfp_scan_pkg::*;
#(
    parameter int unsigned QSFP_COUNT    = 2,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned FREEZE_SETTLE = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bufferUpdated,
    output logic [$clog2(QSFP_COUNT)+7:0] readAddress,
    input  logic [7:0]                    readData,
    output logic                          bufferFreeze,
    output logic                          scanBusy,
    output logic                          scanDone,
    output logic [15:0]                   scanCount,
    output logic [QSFP_COUNT*16-1:0]      tempOut,
    output logic [QSFP_COUNT*16-1:0]      vccOut,
    output logic [QSFP_COUNT*64-1:0]      rxPowerOut,
    input  logic [15:0]                   tempHighLimit,
    input  logic [15:0]                   rxLowLimit,
    output logic [QSFP_COUNT-1:0]         alarm
);

    localparam int unsigned AW       = $clog2(QSFP_COUNT) + 8;
    localparam int unsigned MW       = (QSFP_COUNT > 1) ? $clog2(QSFP_COUNT) : 1;
    localparam int unsigned CW       = 8;
    localparam int unsigned MOD_BITS = NWORDS * 16;

    scan_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [MW-1:0] mod, mod_n;
    logic [3:0]    idx, idx_n;
    logic          sample;
    logic          pending;
    logic          busy;
    logic [15:0]   scan_cnt;
    logic [QSFP_COUNT*MOD_BITS-1:0] shadow;

    assign bufferFreeze = busy;
    assign scanBusy     = busy;
    assign scanCount    = scan_cnt;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mod_n   = mod;
        idx_n   = idx;
        sample  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bufferUpdated || pending) begin
                    state_n = (FREEZE_SETTLE == 0) ? S_ADDR : S_FREEZE;
                    cnt_n   = '0;
                    mod_n   = '0;
                    idx_n   = '0;
                end
            end
            S_FREEZE: begin
                if (cnt == CW'(FREEZE_SETTLE - 1)) state_n = S_ADDR;
                else cnt_n = cnt + 1'b1;
            end
            S_ADDR: begin
                state_n = S_WAIT;
                cnt_n   = '0;
            end
            S_WAIT: begin
                if (cnt == CW'(READ_LATENCY - 1)) begin
                    sample  = 1'b1;
                    state_n = S_ADDR;
                    if (idx == 4'(NBYTES - 1)) begin
                        idx_n = '0;
                        if (mod == MW'(QSFP_COUNT - 1)) state_n = S_PUBLISH;
                        else mod_n = mod + 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PUBLISH: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mod         <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            busy        <= 1'b0;
            scanDone    <= 1'b0;
            scan_cnt    <= '0;
            readAddress <= '0;
            shadow      <= '0;
            tempOut     <= '0;
            vccOut      <= '0;
            rxPowerOut  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mod      <= mod_n;
            idx      <= idx_n;
            scanDone <= 1'b0;

            if (state == S_IDLE) pending <= 1'b0;
            else if (bufferUpdated) pending <= 1'b1;

            if (state == S_IDLE && state_n != S_IDLE) busy <= 1'b1;
            else if (state == S_PUBLISH) busy <= 1'b0;

            // Address is registered on entry to ADDR so the buffer sees it for the whole byte slot.
            if (state_n == S_ADDR)
                readAddress <= (AW'(mod_n) << 8) | AW'(BYTE_OFFSET[idx_n]);

            if (sample)
                shadow[MOD_BITS*int'(mod) + 16*int'(idx[3:1]) + (idx[0] ? 0 : 8) +: 8] <= readData;

            if (state == S_PUBLISH) begin
                scanDone <= 1'b1;
                scan_cnt <= scan_cnt + 16'd1;
                for (int unsigned m = 0; m < QSFP_COUNT; m++) begin
                    tempOut[16*m +: 16]    <= shadow[MOD_BITS*m + 16*W_TEMP +: 16];
                    vccOut[16*m +: 16]     <= shadow[MOD_BITS*m + 16*W_VCC +: 16];
                    rxPowerOut[64*m +: 64] <= shadow[MOD_BITS*m + 16*W_RX0 +: 64];
                end
            end
        end
    end

`ifdef QSFP_SCAN_ALARM_EN
    logic [QSFP_COUNT-1:0] alarm_n;

    for (genvar g = 0; g < QSFP_COUNT; g++) begin : g_alarm
        qsfp_scan_alarm u_alarm (
            .temp            (shadow[MOD_BITS*g + 16*W_TEMP +: 16]),
            .rx_power        (shadow[MOD_BITS*g + 16*W_RX0 +: 64]),
            .temp_high_limit (tempHighLimit),
            .rx_low_limit    (rxLowLimit),
            .alarm           (alarm_n[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm <= '0;
        else if (state == S_PUBLISH) alarm <= alarm_n;
    end
`else
    logic unused_limits;
    assign unused_limits = ^{tempHighLimit, rxLowLimit};
    assign alarm = '0;
`endif

endmodule

// File: tb/tb_qsfp_scan_decode.sv
// tb_qsfp_scan_decode: directed + random scans against a byte-buffer model and reference decoder.
// Honours QSFP_SCAN_ALARM_EN for the expected alarm values.
module tb_qsfp_scan_decode;

    logic         clk = 1'b0;
    logic         rst, rst3, upd, upd3;
    logic [15:0]  thigh, rxlow;
    logic [8:0]   addr, addr3;
    logic [7:0]   rdata, rdata3;
    logic         freeze, busy, done, freeze3, busy3, done3;
    logic [15:0]  cnt, cnt3;
    logic [31:0]  temp, vcc, temp3, vcc3;
    logic [127:0] rx, rx3;
    logic [1:0]   alarm, alarm3;

    logic [7:0]   mem [0:511];
    logic [7:0]   pipe3 [0:2];

    int total = 0;
    int bad   = 0;
    int off [12] = '{22, 23, 26, 27, 34, 35, 36, 37, 38, 39, 40, 41};

    logic [31:0]  exp_temp, exp_vcc, pub_temp, pub_vcc;
    logic [127:0] exp_rx, pub_rx;
    logic [1:0]   exp_alarm, pub_alarm, t5_alarm;
    logic [15:0]  exp_count;
    int           freeze_low, out_changed;
    logic [8:0]   addrs [$];

    always #5 clk = ~clk;

    qsfp_scan_decode #(.QSFP_COUNT(2), .READ_LATENCY(1), .FREEZE_SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .bufferUpdated(upd), .readAddress(addr), .readData(rdata),
        .bufferFreeze(freeze), .scanBusy(busy), .scanDone(done), .scanCount(cnt),
        .tempOut(temp), .vccOut(vcc), .rxPowerOut(rx),
        .tempHighLimit(thigh), .rxLowLimit(rxlow), .alarm(alarm)
    );

    qsfp_scan_decode #(.QSFP_COUNT(2), .READ_LATENCY(3), .FREEZE_SETTLE(2)) u_dut3 (
        .clk(clk), .rst(rst3), .bufferUpdated(upd3), .readAddress(addr3), .readData(rdata3),
        .bufferFreeze(freeze3), .scanBusy(busy3), .scanDone(done3), .scanCount(cnt3),
        .tempOut(temp3), .vccOut(vcc3), .rxPowerOut(rx3),
        .tempHighLimit(thigh), .rxLowLimit(rxlow), .alarm(alarm3)
    );

    // Poller buffer: data for an address appears READ_LATENCY clocks after it is presented.
    always @(posedge clk) begin
        rdata    <= mem[addr];
        pipe3[0] <= mem[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign rdata3 = pipe3[2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    endtask

    task automatic compute_expect();
        for (int m = 0; m < 2; m++) begin
            exp_temp[16*m +: 16] = {mem[m*256 + 22], mem[m*256 + 23]};
            exp_vcc[16*m +: 16]  = {mem[m*256 + 26], mem[m*256 + 27]};
            for (int l = 0; l < 4; l++)
                exp_rx[64*m + 16*l +: 16] = {mem[m*256 + 34 + 2*l], mem[m*256 + 35 + 2*l]};
            exp_alarm[m] = 1'b0;
`ifdef QSFP_SCAN_ALARM_EN
            if ($signed(exp_temp[16*m +: 16]) > $signed(thigh)) exp_alarm[m] = 1'b1;
            for (int l = 0; l < 4; l++)
                if (exp_rx[64*m + 16*l +: 16] < rxlow) exp_alarm[m] = 1'b1;
`endif
        end
    endtask

    // One full scan on u_dut; with strobe=0 the scan is expected to start from a pending flag.
    task automatic scan1(input int extra, input bit strobe);
        int n;
        int left;
        int mism;
        logic [8:0] last;
        left = extra;
        freeze_low = 0;
        out_changed = 0;
        addrs.delete();
        compute_expect();
        last = addr;
        if (strobe) upd = 1'b1;
        @(posedge clk); #1 upd = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            if (!freeze || !busy) freeze_low++;
            if (temp !== pub_temp || vcc !== pub_vcc || rx !== pub_rx ||
                cnt !== exp_count || alarm !== pub_alarm) out_changed++;
            if (addr !== last) begin
                addrs.push_back(addr);
                last = addr;
            end
            upd = (left > 0 && n % 10 == 5);
            if (upd) left--;
            @(posedge clk); #1 n++;
        end
        upd = 1'b0;
        mism = 0;
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 12; k++) begin
                if (m*12 + k >= addrs.size()) mism++;
                else if (addrs[m*12 + k] !== 9'(m*256 + off[k])) mism++;
            end
        exp_count++;
        check("scan_len", n, 52);
        check("freeze_held", freeze_low, 0);
        check("no_early_update", out_changed, 0);
        check("addr_count", addrs.size(), 24);
        check("addr_order", mism, 0);
        check("temp", temp, exp_temp);
        check("vcc", vcc, exp_vcc);
        check("rx", rx, exp_rx);
        check("alarm", alarm, exp_alarm);
        check("scan_count", cnt, exp_count);
        pub_temp = exp_temp;
        pub_vcc = exp_vcc;
        pub_rx = exp_rx;
        pub_alarm = exp_alarm;
    endtask

    initial begin
        int n3;
        int busy_cycles;
        rst = 1'b1; rst3 = 1'b1; upd = 1'b0; upd3 = 1'b0;
        thigh = 16'h3000; rxlow = 16'h0010;
        pub_temp = '0; pub_vcc = '0; pub_rx = '0; pub_alarm = '0; exp_count = '0;
        rand_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst3 = 1'b0;

        check("rst_addr", addr, 0);
        check("rst_freeze", freeze, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", cnt, 0);
        check("rst_words", {temp, vcc, rx}, 0);
        check("rst_alarm", alarm, 0);

        // Directed temperature pattern, single strobe.
        mem[9'h016] = 8'h19; mem[9'h017] = 8'h80;
        mem[9'h116] = 8'hFF; mem[9'h117] = 8'h00;
        scan1(0, 1'b1);
        check("t1_temp_const", temp, 32'hFF00_1980);
        check("t1_count_const", cnt, 1);
        @(posedge clk); #1;
        check("done_pulse_width", done, 0);

        // Three strobes mid-scan coalesce into one rescan right after publish.
        rand_mem();
        scan1(3, 1'b1);
        scan1(0, 1'b0);
        busy_cycles = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (busy) busy_cycles++;
        end
        check("no_third_scan", busy_cycles, 0);
        check("t3_count", cnt, 3);

        // Random buffer contents and thresholds.
        repeat (3) begin
            rand_mem();
            thigh = 16'($urandom);
            rxlow = 16'($urandom_range(0, 16'h2000));
            scan1(0, 1'b1);
        end

        // Reset while module 1 byte 7 is being addressed.
        rand_mem();
        upd = 1'b1;
        @(posedge clk); #1 upd = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mid_addr", addr, 9'h125);
        rst = 1'b1;
        #1;
        check("mid_rst_freeze", freeze, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_words", {temp, vcc, rx}, 0);
        check("mid_rst_count", cnt, 0);
        check("mid_rst_alarm", alarm, 0);
        @(posedge clk); #1 rst = 1'b0;
        pub_temp = '0; pub_vcc = '0; pub_rx = '0; pub_alarm = '0; exp_count = '0;
        scan1(0, 1'b1);

        // Alarm scenario: mod0 RX lane 3 below limit, temperatures under limit.
        rand_mem();
        thigh = 16'h3000; rxlow = 16'h0010;
        for (int m = 0; m < 2; m++)
            for (int l = 0; l < 4; l++) begin
                mem[m*256 + 34 + 2*l] = 8'h01;
                mem[m*256 + 35 + 2*l] = 8'h00;
            end
        mem[9'h016] = 8'h19; mem[9'h017] = 8'h80;
        mem[9'h116] = 8'h20; mem[9'h117] = 8'h00;
        mem[9'h028] = 8'h00; mem[9'h029] = 8'h0F;
`ifdef QSFP_SCAN_ALARM_EN
        t5_alarm = 2'b01;
`else
        t5_alarm = 2'b00;
`endif
        scan1(0, 1'b1);
        check("t5_alarm_const", alarm, t5_alarm);

        // Counter wrap.
        @(posedge clk); #1;
        force u_dut.scan_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release u_dut.scan_cnt;
        exp_count = 16'hFFFF;
        scan1(0, 1'b1);
        check("wrap_count", cnt, 16'h0000);

        // Longer read latency: same data, longer scan.
        rand_mem();
        mem[9'h016] = 8'h19; mem[9'h017] = 8'h80;
        mem[9'h116] = 8'hFF; mem[9'h117] = 8'h00;
        compute_expect();
        upd3 = 1'b1;
        @(posedge clk); #1 upd3 = 1'b0;
        n3 = 1;
        while (!done3 && n3 < 300) begin
            @(posedge clk); #1 n3++;
        end
        check("rl3_scan_len", n3, 100);
        check("rl3_temp_const", temp3, 32'hFF00_1980);
        check("rl3_temp", temp3, exp_temp);
        check("rl3_vcc", vcc3, exp_vcc);
        check("rl3_rx", rx3, exp_rx);
        check("rl3_alarm", alarm3, exp_alarm);
        check("rl3_count", cnt3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
